// File: rtl/addr_pkg.sv
// Shared constants and types for the weight address queue.
// Optional per-entry reuse is enabled with ADDR_QUEUE_REUSE_EN.
package addr_pkg;

    localparam int ADDR_W = 5;
    localparam int LANES  = 4;
    localparam int SET_W  = LANES * ADDR_W;

    typedef struct packed {
        logic [SET_W-1:0] row;
        logic [SET_W-1:0] col;
        logic [SET_W-1:0] ker;
    } addr_set_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/addr_queue_ptr.sv
// Pointer, occupancy and full/empty tracking for addr_queue_rf.
// Pop here means "retire the head"; the top decides when that happens.
module addr_queue_ptr
    import addr_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic push_ok;
    logic pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
            else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/addr_queue_rf.sv
// FWFT queue of {row, col, ker} weight address sets.
// Define ADDR_QUEUE_REUSE_EN to present each head reuse_in+1 times.
module addr_queue_rf
    import addr_pkg::*;
#(
    parameter int LANES  = addr_pkg::LANES,
    parameter int ADDR_W = addr_pkg::ADDR_W,
    parameter int DEPTH  = 4,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [LANES*ADDR_W-1:0] row_in,
    input  logic [LANES*ADDR_W-1:0] col_in,
    input  logic [LANES*ADDR_W-1:0] ker_in,
`ifdef ADDR_QUEUE_REUSE_EN
    input  logic [3:0]              reuse_in,
`endif
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [LANES*ADDR_W-1:0] row_out,
    output logic [LANES*ADDR_W-1:0] col_out,
    output logic [LANES*ADDR_W-1:0] ker_out,
    output logic [CNT_W-1:0]        count
);

    localparam int SW    = LANES * ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);

    logic [SW-1:0]    row_mem [DEPTH];
    logic [SW-1:0]    col_mem [DEPTH];
    logic [SW-1:0]    ker_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             retire;

    assign wr_ready = ~full;
    assign rd_valid = ~empty;
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;

    addr_queue_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .pop     (retire),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                row_mem[i] <= '0;
                col_mem[i] <= '0;
                ker_mem[i] <= '0;
            end
        end else if (push && !flush) begin
            row_mem[wr_ptr] <= row_in;
            col_mem[wr_ptr] <= col_in;
            ker_mem[wr_ptr] <= ker_in;
        end
    end

`ifdef ADDR_QUEUE_REUSE_EN
    logic [3:0]       reuse_mem [DEPTH];
    logic [3:0]       reuse_cnt;
    logic [PTR_W-1:0] nxt_ptr;

    assign nxt_ptr = rd_ptr + PTR_W'(1);
    assign retire  = pop & (reuse_cnt == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) reuse_mem[i] <= '0;
        end else if (push && !flush) begin
            reuse_mem[wr_ptr] <= reuse_in;
        end
    end

    // A push landing in the next head slot is not in storage yet.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reuse_cnt <= '0;
        end else if (flush) begin
            reuse_cnt <= '0;
        end else if (retire) begin
            if (push && wr_ptr == nxt_ptr) reuse_cnt <= reuse_in;
            else                           reuse_cnt <= reuse_mem[nxt_ptr];
        end else if (pop) begin
            reuse_cnt <= reuse_cnt - 4'd1;
        end else if (push && empty) begin
            reuse_cnt <= reuse_in;
        end
    end
`else
    assign retire = pop;
`endif

    always_comb begin
        row_out = '0;
        col_out = '0;
        ker_out = '0;
        if (rd_valid) begin
            row_out = row_mem[rd_ptr];
            col_out = col_mem[rd_ptr];
            ker_out = ker_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_addr_queue_rf.sv
// Randomised and directed self-checking bench for addr_queue_rf.
// Build with ADDR_QUEUE_REUSE_EN to exercise head reuse.
module tb_addr_queue_rf;

    localparam int DEPTH = 4;
    localparam int SW    = 20;
    localparam int CNT_W = 3;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             wr_valid;
    logic             wr_ready;
    logic [SW-1:0]    row_in;
    logic [SW-1:0]    col_in;
    logic [SW-1:0]    ker_in;
    logic [3:0]       reuse_in;
    logic             rd_valid;
    logic             rd_ready;
    logic [SW-1:0]    row_out;
    logic [SW-1:0]    col_out;
    logic [SW-1:0]    ker_out;
    logic [CNT_W-1:0] count;

    typedef struct {
        logic [SW-1:0] row;
        logic [SW-1:0] col;
        logic [SW-1:0] ker;
        int            reuse;
    } ent_t;

    ent_t mq[$];
    int   head_left;
    int   checks;
    int   errors;

    always #5 clock = ~clock;

    addr_queue_rf #(.LANES(4), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .row_in   (row_in),
        .col_in   (col_in),
        .ker_in   (ker_in),
`ifdef ADDR_QUEUE_REUSE_EN
        .reuse_in (reuse_in),
`endif
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .row_out  (row_out),
        .col_out  (col_out),
        .ker_out  (ker_out),
        .count    (count)
    );

    // Advance one clock from a falling edge, updating the queue model.
    task automatic cycle();
        bit   do_push;
        bit   do_pop;
        bit   do_retire;
        bit   was_empty;
        ent_t e;
        do_push   = wr_valid && (mq.size() < DEPTH);
        do_pop    = rd_ready && (mq.size() > 0);
        was_empty = (mq.size() == 0);
        e.row   = row_in;
        e.col   = col_in;
        e.ker   = ker_in;
        e.reuse = int'(reuse_in);
        @(posedge clock);
        if (flush) begin
            mq.delete();
            head_left = 0;
        end else begin
            do_retire = do_pop && (head_left == 0);
            if (do_pop && !do_retire) head_left--;
            if (do_retire) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
            if ((do_retire || (do_push && was_empty)) && mq.size() > 0)
                head_left = mq[0].reuse;
        end
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        row_in   = '0;
        col_in   = '0;
        ker_in   = '0;
        reuse_in = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        mq.delete();
        head_left = 0;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wr_ready got %b want 1", wr_ready);
        end
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_valid got %b want 0", rd_valid);
        end
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        checks++;
        if (row_out !== '0 || col_out !== '0 || ker_out !== '0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h want 0", row_out, col_out, ker_out);
        end
    endtask

    task automatic test_fill();
        logic [SW-1:0] want;
        wr_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            row_in = SW'(i);
            col_in = SW'($urandom);
            ker_in = SW'($urandom);
            cycle();
        end
        checks++;
        if (count !== 3'd4 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got count=%0d wr_ready=%b want 4/0", count, wr_ready);
        end
        row_in = 20'h000FF;
        cycle();
        wr_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL fill_drop count got %0d want 4", count);
        end
        rd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            want = SW'(i);
            checks++;
            if (rd_valid !== 1'b1 || row_out !== want || col_out !== mq[0].col
                || ker_out !== mq[0].ker) begin
                errors++;
                $display("FAIL fill_pop%0d got v=%b row=%h want 1/%h", i, rd_valid, row_out, want);
            end
            cycle();
        end
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL fill_empty got v=%b count=%0d want 0/0", rd_valid, count);
        end
    endtask

    task automatic test_concurrent();
        wr_valid = 1'b1;
        repeat (2) begin
            row_in = SW'($urandom);
            col_in = SW'($urandom);
            ker_in = SW'($urandom);
            cycle();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (count !== 3'd2 || row_out !== mq[0].row || col_out !== mq[0].col
                || ker_out !== mq[0].ker) begin
                errors++;
                $display("FAIL concurrent%0d got count=%0d row=%h want 2/%h",
                         i, count, row_out, mq[0].row);
            end
            row_in = SW'($urandom);
            col_in = SW'($urandom);
            ker_in = SW'($urandom);
            cycle();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (row_out !== mq[0].row || ker_out !== mq[0].ker) begin
                errors++;
                $display("FAIL concurrent_drain%0d got %h want %h", i, row_out, mq[0].row);
            end
            cycle();
        end
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL concurrent_empty rd_valid got %b want 0", rd_valid);
        end
    endtask

    task automatic test_flush();
        wr_valid = 1'b1;
        repeat (3) begin
            row_in = SW'($urandom);
            col_in = SW'($urandom);
            ker_in = SW'($urandom);
            cycle();
        end
        flush    = 1'b1;
        rd_ready = 1'b1;
        row_in   = 20'h12345;
        cycle();
        flush    = 1'b0;
        rd_ready = 1'b0;
        wr_valid = 1'b0;
        checks++;
        if (count !== '0 || rd_valid !== 1'b0 || row_out !== '0) begin
            errors++;
            $display("FAIL flush_clear got count=%0d v=%b row=%h want 0/0/0",
                     count, rd_valid, row_out);
        end
        wr_valid = 1'b1;
        row_in   = 20'h0ABCD;
        cycle();
        wr_valid = 1'b0;
        checks++;
        if (count !== 3'd1 || row_out !== 20'h0ABCD) begin
            errors++;
            $display("FAIL flush_after got count=%0d row=%h want 1/0abcd", count, row_out);
        end
        rd_ready = 1'b1;
        cycle();
        rd_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        wr_valid = 1'b1;
        repeat (2) begin
            row_in = SW'($urandom);
            cycle();
        end
        wr_valid = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (count !== '0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got count=%0d v=%b want 0/0", count, rd_valid);
        end
        mq.delete();
        head_left = 0;
        @(negedge clock);
        reset_n = 1'b1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_release wr_ready got %b want 1", wr_ready);
        end
    endtask

`ifdef ADDR_QUEUE_REUSE_EN
    task automatic test_reuse();
        logic [SW-1:0] want;
        wr_valid = 1'b1;
        row_in   = 20'hA1A1A;
        reuse_in = 4'd2;
        cycle();
        row_in   = 20'hB2B2B;
        reuse_in = 4'd0;
        cycle();
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            want = (k < 3) ? 20'hA1A1A : 20'hB2B2B;
            checks++;
            if (row_out !== want) begin
                errors++;
                $display("FAIL reuse_pop%0d got %h want %h", k, row_out, want);
            end
            cycle();
        end
        rd_ready = 1'b0;
        checks++;
        if (count !== '0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reuse_done got count=%0d v=%b want 0/0", count, rd_valid);
        end
    endtask
`endif

    task automatic test_random();
        logic [SW-1:0] er;
        logic [SW-1:0] ec;
        logic [SW-1:0] ek;
        for (int i = 0; i < 400; i++) begin
            er = (mq.size() > 0) ? mq[0].row : '0;
            ec = (mq.size() > 0) ? mq[0].col : '0;
            ek = (mq.size() > 0) ? mq[0].ker : '0;
            checks++;
            if (rd_valid !== (mq.size() > 0) || wr_ready !== (mq.size() < DEPTH)
                || count !== CNT_W'(mq.size())) begin
                errors++;
                $display("FAIL random_flags@%0d got v=%b r=%b c=%0d want size %0d",
                         i, rd_valid, wr_ready, count, mq.size());
            end
            checks++;
            if (row_out !== er || col_out !== ec || ker_out !== ek) begin
                errors++;
                $display("FAIL random_data@%0d got %h/%h/%h want %h/%h/%h",
                         i, row_out, col_out, ker_out, er, ec, ek);
            end
            flush    = ($urandom_range(0, 24) == 0);
            wr_valid = ($urandom_range(0, 99) < 60);
            rd_ready = ($urandom_range(0, 99) < 50);
            row_in   = SW'($urandom);
            col_in   = SW'($urandom);
            ker_in   = SW'($urandom);
`ifdef ADDR_QUEUE_REUSE_EN
            reuse_in = 4'($urandom_range(0, 2));
`endif
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        head_left = 0;
        test_reset();
        test_fill();
        test_concurrent();
        test_flush();
        test_async_reset();
`ifdef ADDR_QUEUE_REUSE_EN
        test_reuse();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
